// File: rtl/z16_fetch_unit.sv
// rtl/z16_fetch_unit.sv - Z16 instruction fetch: PC, single-outstanding imem request, prefetch FIFO
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t         state, state_nxt;
  logic [15:0]    fetch_pc, fetch_pc_nxt;
  logic           req_nxt;
  logic [15:0]    addr_nxt;
  logic [CW-1:0]  count, count_nxt, count_after;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [15:0]    instr_mem [BUF_DEPTH];
  logic [15:0]    pc_mem    [BUF_DEPTH];
  logic           push, pop;
  logic [15:0]    redirect_pc_al;
  logic [15:0]    pc_inc;

  assign redirect_pc_al = i_redirect_pc & 16'hFFFE;
  assign pc_inc         = fetch_pc + 16'd2;
  assign o_valid        = (count != '0);
  assign o_instr        = instr_mem[rd_ptr];
  assign o_pc           = pc_mem[rd_ptr];
  assign pop            = o_valid && i_ready;
  // occupancy once the word being acked lands, net of this cycle's pop
  assign count_after    = count + CW'(1) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = o_imem_req;
    addr_nxt     = o_imem_addr;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (i_redirect) begin
          fetch_pc_nxt = redirect_pc_al;
        end else if (count < DEPTH_C) begin
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          fetch_pc_nxt = redirect_pc_al;
          if (i_imem_ack) begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = DISCARD;
          end
        end else if (i_imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = pc_inc;
          if (count_after < DEPTH_C) begin
            addr_nxt = pc_inc;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (i_redirect) fetch_pc_nxt = redirect_pc_al;
        if (i_imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (i_redirect) count_nxt = '0;
    else            count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      o_imem_req  <= 1'b0;
      o_imem_addr <= 16'h0000;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      o_imem_req  <= req_nxt;
      o_imem_addr <= addr_nxt;
      count       <= count_nxt;
      if (i_redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_mem[i] <= 16'h0000;
        pc_mem[i]    <= 16'h0000;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= i_imem_rdata;
      pc_mem[wr_ptr]    <= o_imem_addr;
    end
  end

endmodule
